// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel over five-pixel beats with two
// line buffers; emits |Sx|>>2 and |Sy|>>2 per lane, borders forced to zero.
module sobel_gradient #(
  parameter int WIDTH_BEATS = 128,
  parameter int HEIGHT      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] gx,
  output logic [39:0] gy,
  output logic        out_sof,
  output logic        out_eol
);

  localparam int CW = $clog2(WIDTH_BEATS);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_BEATS - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] TAIL  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic [39:0] top_mem [WIDTH_BEATS];
  logic [39:0] mid_mem [WIDTH_BEATS];
  logic [39:0] top_rd, mid_rd;

  logic [39:0] wt_q, wt_d;
  logic [39:0] wm_q, wm_d;
  logic [39:0] wb_q, wb_d;
  logic [7:0]  lt_q, lt_d;
  logic [7:0]  lm_q, lm_d;
  logic [7:0]  lb_q, lb_d;

  logic        ov_q, ov_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic [39:0] gx_q, gx_d;
  logic [39:0] gy_q, gy_d;

  logic        adv;
  logic        accept;
  logic [7:0]  ct [7];
  logic [7:0]  cm [7];
  logic [7:0]  cb [7];
  logic [39:0] sx, sy;

  // |(a0 + 2a1 + a2) - (b0 + 2b1 + b2)| >> 2
  function automatic logic [7:0] grad(
    input logic [7:0] a0,
    input logic [7:0] a1,
    input logic [7:0] a2,
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    logic [9:0]  pa;
    logic [9:0]  pb;
    logic [10:0] d;
    logic [10:0] m;
    pa = {2'b00, a0} + {1'b0, a1, 1'b0} + {2'b00, a2};
    pb = {2'b00, b0} + {1'b0, b1, 1'b0} + {2'b00, b2};
    d  = {1'b0, pa} - {1'b0, pb};
    m  = d[10] ? (~d + 11'd1) : d;
    return 8'(m >> 2);
  endfunction

  assign top_rd = top_mem[col_q];
  assign mid_rd = mid_mem[col_q];

  assign adv      = !ov_q || out_ready;
  assign in_ready = !reset &&
                    ((state_q == FILL) || ((state_q == RUN) && adv));
  assign accept   = in_valid && in_ready;

  // Seven columns: left of previous beat, its five lanes, current lane 0.
  always_comb begin
    for (int j = 0; j < 7; j++) begin
      ct[j] = '0;
      cm[j] = '0;
      cb[j] = '0;
    end
    ct[0] = lt_q;
    cm[0] = lm_q;
    cb[0] = lb_q;
    for (int j = 0; j < 5; j++) begin
      ct[j+1] = wt_q[8*j +: 8];
      cm[j+1] = wm_q[8*j +: 8];
      cb[j+1] = wb_q[8*j +: 8];
    end
    ct[6] = top_rd[7:0];
    cm[6] = mid_rd[7:0];
    cb[6] = in_pix[7:0];
    sx = '0;
    sy = '0;
    for (int j = 0; j < 5; j++) begin
      sx[8*j +: 8] = grad(ct[j+2], cm[j+2], cb[j+2],
                          ct[j],   cm[j],   cb[j]);
      sy[8*j +: 8] = grad(cb[j], cb[j+1], cb[j+2],
                          ct[j], ct[j+1], ct[j+2]);
    end
    if (row_q == ROW_ONE) begin
      sx = '0;
      sy = '0;
    end
    if ((state_q == RUN) && (col_q == COL_ONE)) begin
      sx[7:0] = '0;
      sy[7:0] = '0;
    end
    if (state_q == TAIL) begin
      sx[39:32] = '0;
      sy[39:32] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ov_d    = ov_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    wt_d    = wt_q;
    wm_d    = wm_q;
    wb_d    = wb_q;
    lt_d    = lt_q;
    lm_d    = lm_q;
    lb_d    = lb_q;
    if (accept) begin
      lt_d = wt_q[39:32];
      lm_d = wm_q[39:32];
      lb_d = wb_q[39:32];
      wt_d = top_rd;
      wm_d = mid_rd;
      wb_d = in_pix;
    end
    unique case (state_q)
      FILL: begin
        if (adv) ov_d = 1'b0;
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = ROW_ONE;
            state_d = RUN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (adv) ov_d = accept && (col_q != '0);
        if (accept) begin
          if (col_q != '0) begin
            gx_d  = sx;
            gy_d  = sy;
            sof_d = (row_q == ROW_ONE) && (col_q == COL_ONE);
            eol_d = 1'b0;
          end
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = TAIL;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (adv) begin
          ov_d  = 1'b1;
          gx_d  = sx;
          gy_d  = sy;
          sof_d = 1'b0;
          eol_d = 1'b1;
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = FLUSH;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          ov_d  = 1'b1;
          gx_d  = '0;
          gy_d  = '0;
          sof_d = 1'b0;
          eol_d = (col_q == COL_LAST);
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = '0;
            state_d = FILL;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
      ov_q    <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      wt_q    <= '0;
      wm_q    <= '0;
      wb_q    <= '0;
      lt_q    <= '0;
      lm_q    <= '0;
      lb_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ov_q    <= ov_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      wt_q    <= wt_d;
      wm_q    <= wm_d;
      wb_q    <= wb_d;
      lt_q    <= lt_d;
      lm_q    <= lm_d;
      lb_q    <= lb_d;
    end
  end

  // Line buffers are never cleared; row 0 overwrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      top_mem[col_q] <= mid_rd;
      mid_mem[col_q] <= in_pix;
    end
  end

  assign out_valid = ov_q;
  assign gx        = gx_q;
  assign gy        = gy_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;

endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming 3x3 Sobel stage that produces the five-lane unsigned gradient pair (gx[0:4], gy[0:4]) consumed by the gradient-magnitude stage of the Canny pipeline. It accepts raster-order grayscale pixels five per beat, keeps two line buffers, and emits one gradient beat per pixel beat. Gradients are absolute values scaled to 8 bits. Border pixels are zero. Valid/ready handshakes are used on both sides.

## Interface
- WIDTH_BEATS, 128: beats per row (row width = 5*WIDTH_BEATS pixels); minimum 2.
- HEIGHT, 480: rows per frame; minimum 3.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_pix[0:4]  in  8 each  pixels; lane 0 = leftmost column of beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- gx[0:4]  out  8 each  |Sobel X| >> 2 per lane.
- gy[0:4]  out  8 each  |Sobel Y| >> 2 per lane.
- out_sof  out  1  high on output beat (row 0, beat 0).
- out_eol  out  1  high on every output beat WIDTH_BEATS-1.

## Operation
- Counters: row (0..HEIGHT-1) and col (0..WIDTH_BEATS-1) track input position. Frames are delimited by counters only.
- Line buffers: two WIDTH_BEATS x 40-bit arrays. They hold rows r-2 (top) and r-1 (mid). The current input beat is the bottom row. On acceptance of beat col, mid[col] moves to top[col] and the input is written to mid[col].
- Column window: registers hold the 3-row columns of the previous beat, plus the rightmost column of the beat before that. This is enough to compute output beat c-1 when input beat c arrives.
- Sobel for the center at row r-1:
  - Sx = (T[c+1] + 2M[c+1] + B[c+1]) - (T[c-1] + 2M[c-1] + B[c-1])
  - Sy = (B[c-1] + 2B[c] + B[c+1]) - (T[c-1] + 2T[c] + T[c+1])
  - Weighted sums are 10 bits unsigned. Differences are 11 bits signed.
  - |S| <= 1020. Output = |S| >> 2 (truncating), range 0..255, so no saturation.
- Border rule: gx = gy = 0 for row 0, row HEIGHT-1, column 0 (beat 0 lane 0) and column 5*WIDTH_BEATS-1 (last beat lane 4).
- States:
  - FILL: accept row 0 and produce no output. After accepting col WIDTH_BEATS-1: row becomes 1, col becomes 0, go to RUN.
  - RUN: accept beat col of row r. If col >= 1, load output beat col-1 of row r-1. After accepting col WIDTH_BEATS-1, go to TAIL.
  - TAIL: in_ready = 0. Load output beat WIDTH_BEATS-1 of row r-1. Then, if r == HEIGHT-1, go to FLUSH; else r increments and go to RUN.
  - FLUSH: in_ready = 0. Load WIDTH_BEATS all-zero beats for row HEIGHT-1 (out_eol on the last). Then go to FILL with row = col = 0.
- Output register advance: the output register loads only when (!out_valid || out_ready).
  - in_ready = (state is FILL or RUN) && !reset && (state == FILL || !out_valid || out_ready).
  - TAIL and FLUSH steps stall while out_valid && !out_ready.
  - An accept that produces no output (FILL, RUN col 0) clears out_valid if the held beat is taken that cycle.
- Count: exactly WIDTH_BEATS*HEIGHT output beats per frame, in raster order, with no drop or duplicate under any out_ready pattern.

## Timing
- Reset values: out_valid 0, gx/gy all 0, out_sof 0, out_eol 0, in_ready 0 while reset is high. State = FILL, row = col = 0.
- Line-buffer contents are not cleared; FILL overwrites them.
- Reset mid-frame: the partial frame is discarded, any pending output beat is dropped, and the next accepted beat is row 0 col 0.
- Latency: output beat (row 0, beat 0) is valid in the cycle after acceptance of input beat index WIDTH_BEATS+1 (row 1, beat 1). In general, output beat c-1 follows its enabling input by 1 cycle.
- Throughput with out_ready = 1: one input per cycle, plus one TAIL bubble per row after row 0, plus WIDTH_BEATS flush cycles per frame.
- Buffer reads are combinational from register arrays, so results are registered in one stage.

## Test plan
- Flat frame, WIDTH_BEATS = 2, HEIGHT = 3, all pixels 100 -> 6 output beats, all gx = gy = 0; out_sof on beat 1; out_eol on beats 2, 4, 6.
- Vertical step, 2x3: columns 0-4 = 0, columns 5-9 = 200 -> row 1 beat 0 lane 4 and beat 1 lane 0 give gx = 200, gy = 0; all other lanes/rows 0. Mirrored step (200 left, 0 right) gives the same gx = 200.
- Horizontal step, 2x3: row 0 = 0, rows 1-2 = 255 -> row 1 columns 1-8 give gy = 255, gx = 0; columns 0 and 9 give 0; rows 0 and 2 all 0.
- Backpressure: repeat the vertical-step frame with out_ready pattern 1,0,0,1,… and random in_valid -> identical 6-beat sequence; in_ready = 0 whenever out_valid && !out_ready in RUN.
- Reset mid-frame: accept 3 beats, assert reset for 1 cycle -> out_valid = 0 next cycle; the following full frame reproduces the horizontal-step output exactly.
- Back-to-back frames, WIDTH_BEATS = 2, HEIGHT = 4, random pixels -> 8 beats per frame matching the reference-model Sobel; out_sof exactly once per frame; FLUSH beats all zero.
